// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone bus arbiter with a slave-response watchdog.
//
// Grants one of MASTER_COUNT masters at a time and holds the grant for the whole
// bus cycle. A watchdog aborts a transfer that the slave never answers, so a dead
// slave cannot lock the bus.
//
// Ports:
//   clk_i      in   1             clock, all state on rising edge
//   rst_n_i    in   1             asynchronous active-low reset
//   cyc_i      in   MASTER_COUNT  per-master cycle request (bit k = master k)
//   stb_i      in   1             strobe of the granted master (muxed upstream)
//   ack_i      in   1             OR of slave acks
//   err_i      in   1             OR of slave errors
//   rty_i      in   1             OR of slave retries
//   gnt_o      out  GNT_WIDTH     granted master index (registered)
//   gnt_vld_o  out  1             grant valid, OWNED or ABORT (registered)
//   cyc_o      out  1             cycle to slaves, cyc_i[gnt_o] while OWNED (combinational)
//   tmo_o      out  1             one-cycle watchdog error pulse (registered)

module wb_rr_arbiter #(
  parameter int unsigned MASTER_COUNT = 2,
  parameter int unsigned GNT_WIDTH    = $clog2(MASTER_COUNT),
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_WIDTH    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [MASTER_COUNT-1:0] cyc_i,
  input  logic                    stb_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    rty_i,
  output logic [GNT_WIDTH-1:0]    gnt_o,
  output logic                    gnt_vld_o,
  output logic                    cyc_o,
  output logic                    tmo_o
);

  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [GNT_WIDTH-1:0]    gnt_q, gnt_d;
  logic                    gnt_vld_q, gnt_vld_d;
  logic [GNT_WIDTH-1:0]    last_q, last_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    tmo_q, tmo_d;

  logic [MASTER_COUNT-1:0] req_c;
  logic [GNT_WIDTH-1:0]    base_c;
  logic                    pick_vld_c;
  logic [GNT_WIDTH-1:0]    pick_idx_c;
  logic                    own_req_c;
  logic                    stall_c;

  assign own_req_c = cyc_i[gnt_q];
  assign stall_c   = stb_i & ~(ack_i | err_i | rty_i);

  // Scan origin: the last-served master in IDLE, the releasing master otherwise
  // (it becomes the new last-served); the releasing master is excluded.
  always_comb begin : rr_req
    req_c  = cyc_i;
    base_c = last_q;
    if (state_q != ST_IDLE) begin
      req_c  = cyc_i & ~({{(MASTER_COUNT-1){1'b0}}, 1'b1} << gnt_q);
      base_c = gnt_q;
    end
  end

  // First set request at (base+1), (base+2), ... with wrap; iterating from the
  // farthest offset down lets the nearest one overwrite the result.
  always_comb begin : rr_scan
    int                   idx;
    logic [GNT_WIDTH-1:0] idx_g;
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    idx        = 0;
    idx_g      = '0;
    for (int off = int'(MASTER_COUNT); off >= 1; off--) begin
      idx = int'(base_c) + off;
      if (idx >= int'(MASTER_COUNT)) begin
        idx = idx - int'(MASTER_COUNT);
      end
      idx_g = GNT_WIDTH'(idx);
      if (req_c[idx_g]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = idx_g;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    last_d    = last_q;
    cnt_d     = '0;
    tmo_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          gnt_d     = pick_idx_c;
          gnt_vld_d = 1'b1;
          state_d   = ST_OWNED;
        end
      end

      ST_OWNED, ST_ABORT: begin
        if (!own_req_c) begin
          // Release wins over a same-cycle timeout; hand over or go idle.
          last_d = gnt_q;
          if (pick_vld_c) begin
            gnt_d   = pick_idx_c;
            state_d = ST_OWNED;
          end else begin
            gnt_vld_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (WD_EN && (state_q == ST_OWNED) && stall_c) begin
          if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
            tmo_d   = 1'b1;
            state_d = ST_ABORT;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State registers; last-served starts at N-1 so master 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin : regs
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      last_q    <= GNT_WIDTH'(MASTER_COUNT - 1);
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = gnt_vld_q;
  assign tmo_o     = WD_EN ? tmo_q : 1'b0;
  // State resets asynchronously, so cyc_o drops the moment reset asserts.
  assign cyc_o     = (state_q == ST_OWNED) & own_req_c;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with four masters and a short watchdog.
module tb_wb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] cyc;
  logic       stb;
  logic       ack;
  logic       err;
  logic       rty;
  logic [1:0] gnt;
  logic       gnt_vld;
  logic       cyc_o;
  logic       tmo;

  int vectors;
  int miscompares;

  wb_rr_arbiter #(
    .MASTER_COUNT(4),
    .TIMEOUT     (4)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .cyc_i    (cyc),
    .stb_i    (stb),
    .ack_i    (ack),
    .err_i    (err),
    .rty_i    (rty),
    .gnt_o    (gnt),
    .gnt_vld_o(gnt_vld),
    .cyc_o    (cyc_o),
    .tmo_o    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    cyc   = 4'b0011;
    stb   = 1'b0;
    ack   = 1'b0;
    err   = 1'b0;
    rty   = 1'b0;

    // Reset with requests held
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(gnt_vld), 0);
    chk("rst_tmo", 32'(tmo), 0);
    chk("rst_cyc", 32'(cyc_o), 0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 0);
    chk("first_vld", 32'(gnt_vld), 1);
    chk("first_cyc", 32'(cyc_o), 1);

    // Rotation with all four requesting, one acked transfer per tenure
    cyc = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      stb = 1'b1;
      ack = 1'b1;
      tick();
      stb = 1'b0;
      ack = 1'b0;
      cyc[2'(k)] = 1'b0;
      #1;
      chk("rot_gap_cyc", 32'(cyc_o), 0);
      tick();
      chk("rot_gnt", 32'(gnt), 32'((k + 1) % 4));
      chk("rot_vld", 32'(gnt_vld), 1);
      cyc[2'(k)] = 1'b1;
      #1;
      chk("rot_cyc", 32'(cyc_o), 1);
    end

    // No preemption: master 1 holds while master 0 requests
    cyc = 4'b0010;
    tick();
    chk("hold_gnt1", 32'(gnt), 1);
    cyc = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_keep", 32'(gnt), 1);
      chk("hold_cyc", 32'(cyc_o), 1);
    end
    cyc = 4'b0001;
    #1;
    chk("hold_drop_cyc", 32'(cyc_o), 0);
    tick();
    chk("hold_switch", 32'(gnt), 0);
    chk("hold_switch_cyc", 32'(cyc_o), 1);
    cyc = 4'b0000;
    tick();
    chk("idle_vld", 32'(gnt_vld), 0);
    chk("idle_cyc", 32'(cyc_o), 0);

    // Watchdog abort on master 2
    cyc = 4'b0100;
    tick();
    chk("wd_gnt", 32'(gnt), 2);
    chk("wd_vld", 32'(gnt_vld), 1);
    stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wd_pre_tmo", 32'(tmo), 0);
      chk("wd_pre_cyc", 32'(cyc_o), 1);
    end
    tick();
    chk("wd_tmo", 32'(tmo), 1);
    chk("wd_abort_cyc", 32'(cyc_o), 0);
    chk("wd_abort_gnt", 32'(gnt), 2);
    chk("wd_abort_vld", 32'(gnt_vld), 1);
    tick();
    chk("wd_tmo_once", 32'(tmo), 0);
    chk("wd_hold_gnt", 32'(gnt), 2);
    chk("wd_hold_cyc", 32'(cyc_o), 0);
    stb = 1'b0;
    cyc = 4'b0000;
    tick();
    chk("wd_release_vld", 32'(gnt_vld), 0);

    // Ack on the fifth stalled cycle beats the timeout, counter restarts
    cyc = 4'b1000;
    tick();
    chk("ack5_gnt", 32'(gnt), 3);
    stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ack5_pre_tmo", 32'(tmo), 0);
    end
    ack = 1'b1;
    tick();
    chk("ack5_tmo", 32'(tmo), 0);
    chk("ack5_cyc", 32'(cyc_o), 1);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ack5_restart_tmo", 32'(tmo), 0);
    end
    ack = 1'b1;
    tick();
    chk("ack5_second_tmo", 32'(tmo), 0);
    chk("ack5_second_cyc", 32'(cyc_o), 1);
    ack = 1'b0;
    stb = 1'b0;
    cyc = 4'b0000;
    tick();
    chk("ack5_done_vld", 32'(gnt_vld), 0);

    // Release in the same cycle the count reaches the limit
    cyc = 4'b0001;
    tick();
    chk("rel_gnt", 32'(gnt), 0);
    stb = 1'b1;
    repeat (4) tick();
    cyc = 4'b0000;
    tick();
    chk("rel_tmo", 32'(tmo), 0);
    chk("rel_vld", 32'(gnt_vld), 0);
    stb = 1'b0;

    // Reset mid-transfer on master 1
    cyc = 4'b0010;
    tick();
    chk("mid_gnt", 32'(gnt), 1);
    chk("mid_cyc", 32'(cyc_o), 1);
    cyc = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(cyc_o), 0);
    chk("mid_rst_vld", 32'(gnt_vld), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_tmo", 32'(tmo), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 1);
    chk("post_rst_vld", 32'(gnt_vld), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone bus arbiter for N masters sharing one slave-side bus, such as the two-master wb_interconnect.
- It issues a registered grant index (gnt_o) and a gated cycle (cyc_o), and holds the grant for the whole bus cycle.
- A bus watchdog aborts any transfer the slave never answers and signals an injected error to the interconnect, so a dead slave cannot lock the bus.

Parameters:
- MASTER_COUNT, 2, number of requesting masters (>=2).
- GNT_WIDTH, $clog2(MASTER_COUNT), width of the grant index.
- TIMEOUT, 255, cycles with stb_i high and no slave response before abort; 0 disables the watchdog.
- CNT_WIDTH, $clog2(TIMEOUT+1) (min 1), watchdog counter width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- cyc_i  in  MASTER_COUNT  per-master cycle request, bit k = master k.
- stb_i  in  1  strobe of the currently granted master (already muxed by the interconnect).
- ack_i  in  1  OR of slave acks.
- err_i  in  1  OR of slave errors.
- rty_i  in  1  OR of slave retries.
- gnt_o  out  GNT_WIDTH  index of the granted master, registered.
- gnt_vld_o  out  1  high in OWNED or ABORT state, registered.
- cyc_o  out  1  cycle to slaves: cyc_i[gnt_o] while OWNED, else 0 (combinational from state and cyc_i).
- tmo_o  out  1  one-cycle watchdog error pulse, to be ORed into the granted master's err.

Behaviour:
- Async reset (rst_n_i low):
  - state=IDLE, gnt_o=0, gnt_vld_o=0, tmo_o=0, watchdog count=0.
  - last-served pointer = MASTER_COUNT-1, so master 0 has first priority.
  - cyc_o=0 immediately.
- Reset asserted mid-transfer drops cyc_o in the same cycle. No state survives reset.
- IDLE:
  - cyc_o=0.
  - If any cyc_i bit is set, pick the first set bit scanning (last+1) mod N upward with wrap.
  - Register it into gnt_o, set gnt_vld_o, go OWNED.
  - Grant latency is 1 clock after the request is sampled.
- OWNED:
  - cyc_o=cyc_i[gnt_o]. Grant is held regardless of other requests; no preemption.
  - When cyc_i[gnt_o] is sampled low: last=gnt_o.
    - If other requests are pending, hand over directly to the next round-robin winner, excluding the current master, and stay OWNED.
    - Otherwise go IDLE and clear gnt_vld_o.
  - A handover cycle shows cyc_o=0 for at least that one cycle.
- Watchdog, OWNED only:
  - The counter increments each cycle stb_i=1 and ack_i|err_i|rty_i=0.
  - It clears on any response, on stb_i=0, on a grant change, and on leaving OWNED.
  - When the count reaches TIMEOUT and the current cycle still has stb_i=1 with no response: next edge sets tmo_o=1 and moves to ABORT.
- ABORT:
  - cyc_o forced to 0. tmo_o is high only in the first ABORT cycle.
  - gnt_o is held so the interconnect routes tmo_o to the correct master.
  - When cyc_i[gnt_o] drops, apply the same release/handover rule as OWNED.
- Simultaneous events:
  - Response in the same cycle the count reaches TIMEOUT: the response wins, no tmo_o, counter cleared.
  - cyc_i[gnt_o] low in that same cycle: the release wins, no tmo_o.
- TIMEOUT=0: the watchdog is removed, ABORT is unreachable, tmo_o is tied 0.
- Fairness: with all masters requesting continuously and each releasing after one transfer, grants rotate 0,1,…,N-1,0. No master waits more than N-1 other tenures.

Test Plan:
- Reset with cyc_i=2'b11 held → after rst_n_i rises, gnt_o=0 and gnt_vld_o=1 one clock later; cyc_o follows cyc_i[0].
- MASTER_COUNT=4, cyc_i=4'b1111, each master drops cyc one clock after ack → gnt_o sequence 0,1,2,3,0 with one cyc_o=0 clock between tenures.
- Master 1 holds cyc_i while master 0 requests → gnt_o stays 1 until cyc_i[1] falls, then switches to 0 on the next edge.
- TIMEOUT=4, stb_i=1, no response → tmo_o high exactly one clock, 5 clocks after stb_i first sampled high; cyc_o=0 from that edge; gnt_o held until cyc_i[gnt] drops.
- TIMEOUT=4, ack_i arrives on the 5th stalled cycle → no tmo_o, counter restarts, transfer completes normally.
- rst_n_i pulsed low mid-transfer (OWNED, gnt_o=1) → cyc_o, gnt_vld_o, gnt_o go to 0 asynchronously; first grant afterwards goes to the lowest-index requester.
